// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: instruction-memory and decoder handshake bundle for the fetch stage
interface mips_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        inst_valid;
  logic        inst_ready;
  logic        except;
  modport master (
    output imem_addr, imem_req, inst, opcode, funct, inst_valid,
    input  imem_ack, imem_data, inst_ready, except
  );
  modport slave (
    input  imem_addr, imem_req, inst, opcode, funct, inst_valid,
    output imem_ack, imem_data, inst_ready, except
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC/fetch/issue FSM feeding the decoder, halting on decoder exceptions
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic              clock,
  input  logic              reset,
  mips_fetch_unit_if.master bus,
  output logic [31:0]       pc,
  output logic              halted,
  output logic [31:0]       retire_count
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_ISSUE, S_HALT} state_t;
  state_t state, next;
  logic [31:2] pc_q;
  logic [31:0] inst_q;
  logic        accept;
  assign accept = (state == S_ISSUE) && bus.inst_ready;
  // Storing only the word index keeps pc aligned and makes +4 wrap naturally.
  assign pc             = {pc_q, 2'b00};
  assign bus.imem_addr  = pc;
  assign bus.inst       = inst_q;
  assign bus.opcode     = inst_q[31:26];
  assign bus.funct      = inst_q[5:0];
  // Outputs are masked while reset is held so nothing leaks out of an interrupted state.
  assign bus.imem_req   = (state == S_FETCH) && !reset;
  assign bus.inst_valid = (state == S_ISSUE) && !reset;
  assign halted         = (state == S_HALT) && !reset;
  always_comb begin
    next = S_RESET;
    case (state)
      S_RESET: next = S_FETCH;
      S_FETCH: next = bus.imem_ack ? S_ISSUE : S_FETCH;
      S_ISSUE: next = accept ? (bus.except ? S_HALT : S_FETCH) : S_ISSUE;
      S_HALT:  next = S_HALT;
      default: next = S_RESET;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_RESET;
      pc_q         <= RESET_PC[31:2];
      inst_q       <= '0;
      retire_count <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH && bus.imem_ack) inst_q <= bus.imem_data;
      if (accept && !bus.except) begin
        pc_q         <= pc_q + 30'd1;
        retire_count <= retire_count + 32'd1;
      end
    end
  end
endmodule
